mem_port_arbiter: RTL and testbench

Two-port access arbiter and sequencer for the 8x8-bit memory array. Accepts read/write requests from two requesters (port A, port B) over a req/ack handshake and grants one request at a time. For the granted request it drives the address, select-valid, write-enable and write data into the memory's 3-to-8 select decoder and word array. Read data is returned to the granted port together with its ack.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter and its
// 8x8 array (3-to-8 select decoder, 8-bit words).
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 3;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  // The port that is not g.
  function automatic grant_e other_port(input grant_e g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between port A and port B.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the
// port named by i_ptr; otherwise A always wins a tie and i_ptr is ignored.
// Ports:
//   i_a_req, i_b_req  pending requests
//   i_ptr             preferred port on a tie (round-robin build only)
//   o_any_c           at least one request pending
//   o_gnt_c           winning port (meaningful only when o_any_c=1)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_a_req,
  input  logic   i_b_req,
  input  grant_e i_ptr,
  output logic   o_any_c,
  output grant_e o_gnt_c
);

  assign o_any_c = i_a_req | i_b_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Single requester wins outright; a tie is settled by the pointer.
  always_comb begin
    o_gnt_c = GNT_A;
    if (i_a_req && i_b_req) begin
      o_gnt_c = i_ptr;
    end else if (i_b_req) begin
      o_gnt_c = GNT_B;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = 1'(i_ptr);

  // Fixed priority: B only when A is not asking.
  assign o_gnt_c = (i_b_req && !i_a_req) ? GNT_B : GNT_A;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port req/ack arbiter and sequencer for the 8x8 memory array.
// One request is granted at a time: IDLE -> ACCESS (decoder selected for one
// cycle) -> RESPOND (ack pulse with read data) -> IDLE.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- round-robin tie break with a 1-bit
// pointer; when undefined, fixed priority with A winning and no pointer flop.
// Ports:
//   i_clk, i_rst_n                clock, async active-low reset
//   i_{a,b}_req/we/adr/wdata      requester inputs
//   o_{a,b}_ack, o_{a,b}_rdata    completion pulse and read data per port
//   o_mem_adr/valid/we/wdata      registered decoder/array controls (0 when idle)
//   i_mem_rdata                   combinational read data from the array
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_adr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_adr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic [ADDR_W-1:0] o_mem_adr,
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e              state_q, state_d;
  grant_e              gnt_q, gnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                any_req_c;
  grant_e              win_c;
  grant_e              ptr_c;

  mem_arb_pick u_pick (
    .i_a_req (i_a_req),
    .i_b_req (i_b_req),
    .i_ptr   (ptr_c),
    .o_any_c (any_req_c),
    .o_gnt_c (win_c)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e ptr_q, ptr_d;

  // Pointer moves to the loser of every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_req_c) begin
      ptr_d = other_port(win_c);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= GNT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_c = ptr_q;
`else
  assign ptr_c = GNT_A;
`endif

  // Next state, request capture, ack/rdata and memory-side outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          gnt_d   = win_c;
          adr_d   = (win_c == GNT_B) ? i_b_adr   : i_a_adr;
          we_d    = (win_c == GNT_B) ? i_b_we    : i_a_we;
          wdata_d = (win_c == GNT_B) ? i_b_wdata : i_a_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ack is raised here so its flop is high during RESPOND.
        if (!we_q) begin
          if (gnt_q == GNT_B) b_rdata_d = i_mem_rdata;
          else                a_rdata_d = i_mem_rdata;
        end
        a_ack_d = (gnt_q == GNT_A);
        b_ack_d = (gnt_q == GNT_B);
        state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Decoder controls are flops that are zero outside ACCESS.
    mem_valid_d = (state_d == ACCESS);
    mem_adr_d   = mem_valid_d ? adr_d : '0;
    mem_we_d    = mem_valid_d & we_d;
    mem_wdata_d = mem_valid_d ? wdata_d : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_A;
      adr_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_adr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_adr_q   <= mem_adr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_a_ack     = a_ack_q;
  assign o_b_ack     = b_ack_q;
  assign o_a_rdata   = a_rdata_q;
  assign o_b_rdata   = b_rdata_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_adr   = mem_adr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: an 8x8 array stub behind the memory port and a
// transaction-level model (expected memory image, last read value per port,
// preferred-port bit for round-robin builds).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk, rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_adr, b_adr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_adr;
  logic          mem_valid, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total, bad;

  logic [DW-1:0] arr [8];
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] ref_a_rdata, ref_b_rdata;
  logic          pref_b;
  logic          stub_load;

  mem_port_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_req     (a_req),
    .i_a_we      (a_we),
    .i_a_adr     (a_adr),
    .i_a_wdata   (a_wdata),
    .i_b_req     (b_req),
    .i_b_we      (b_we),
    .i_b_adr     (b_adr),
    .i_b_wdata   (b_wdata),
    .o_a_ack     (a_ack),
    .o_a_rdata   (a_rdata),
    .o_b_ack     (b_ack),
    .o_b_rdata   (b_rdata),
    .o_mem_adr   (mem_adr),
    .o_mem_valid (mem_valid),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stub: writes land on the edge that ends a valid write cycle.
  always @(posedge clk) begin
    if (stub_load) begin
      for (int i = 0; i < 8; i++) arr[i] <= ref_mem[i];
    end else if (mem_valid && mem_we) begin
      arr[mem_adr] <= mem_wdata;
    end
  end
  assign mem_rdata = arr[mem_adr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected winner: 1 = B.
  function automatic logic pick_b(input logic ra, input logic rb);
    if (ra && rb) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return pref_b;
`else
      return 1'b0;
`endif
    end
    return rb;
  endfunction

  task automatic test_reset();
    logic [33:0] outs;
    a_req = 1'b1; a_we = 1'b1; a_adr = AW'($urandom); a_wdata = DW'($urandom);
    b_req = 1'b1; b_we = 1'b0; b_adr = AW'($urandom); b_wdata = DW'($urandom);
    tick(); tick();
    outs = {a_ack, b_ack, a_rdata, b_rdata, mem_valid, mem_we, mem_adr, mem_wdata};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++;
    if ({mem_valid, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b1, a_adr, a_wdata}) begin
      bad++; $display("FAIL reset_first_grant: got %b/%b/%h/%h expected 1/1/%h/%h",
                      mem_valid, mem_we, mem_adr, mem_wdata, a_adr, a_wdata);
    end
    tick();
    total++;
    if ({a_ack, b_ack} !== 2'b10) begin
      bad++; $display("FAIL reset_a_ack: got %b%b expected 10", a_ack, b_ack);
    end
    ref_mem[a_adr] = a_wdata; pref_b = 1'b1;
    a_req = 1'b0;
    tick(); tick();
    total++;
    if ({mem_valid, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b0, b_adr, b_wdata}) begin
      bad++; $display("FAIL reset_loser_grant: got %b/%b/%h/%h expected 1/0/%h/%h",
                      mem_valid, mem_we, mem_adr, mem_wdata, b_adr, b_wdata);
    end
    tick();
    total++;
    if ({a_ack, b_ack, b_rdata} !== {2'b01, ref_mem[b_adr]}) begin
      bad++; $display("FAIL reset_b_ack: got %b%b/%h expected 01/%h", a_ack, b_ack, b_rdata, ref_mem[b_adr]);
    end
    ref_b_rdata = ref_mem[b_adr]; pref_b = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic wb;
    a_req = 1'b1; a_we = 1'b0; a_adr = 3'd1; a_wdata = DW'($urandom);
    b_req = 1'b1; b_we = 1'b0; b_adr = 3'd6; b_wdata = DW'($urandom);
    for (int k = 0; k < 4; k++) begin
      wb = pick_b(1'b1, 1'b1);
      tick(); tick();
      if (wb) ref_b_rdata = ref_mem[6];
      else    ref_a_rdata = ref_mem[1];
      total++;
      if ({a_ack, b_ack, a_rdata, b_rdata} !== {!wb, wb, ref_a_rdata, ref_b_rdata}) begin
        bad++; $display("FAIL contention_%0d: got ack %b%b rd %h/%h expected ack %b%b rd %h/%h", k,
                        a_ack, b_ack, a_rdata, b_rdata, !wb, wb, ref_a_rdata, ref_b_rdata);
      end
      pref_b = !wb;
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_adr = 3'd5; a_wdata = 8'hA5;
    tick();
    total++;
    if ({mem_valid, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b1, 3'd5, 8'hA5}) begin
      bad++; $display("FAIL wr_access: got %b/%b/%h/%h expected 1/1/5/a5", mem_valid, mem_we, mem_adr, mem_wdata);
    end
    tick();
    total++;
    if ({a_ack, b_ack, mem_valid} !== 3'b100) begin
      bad++; $display("FAIL wr_ack: got ack %b%b valid %b expected 10 0", a_ack, b_ack, mem_valid);
    end
    ref_mem[5] = 8'hA5; pref_b = 1'b1;
    a_req = 1'b0;
    tick();
    a_req = 1'b1; a_we = 1'b0; a_wdata = DW'($urandom);
    tick();
    total++;
    if ({mem_valid, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b0, 3'd5, a_wdata}) begin
      bad++; $display("FAIL rd_access: got %b/%b/%h/%h expected 1/0/5/%h", mem_valid, mem_we, mem_adr, mem_wdata, a_wdata);
    end
    tick();
    total++;
    if ({a_ack, a_rdata} !== {1'b1, 8'hA5}) begin
      bad++; $display("FAIL rd_data: got ack %b rd %h expected 1 a5", a_ack, a_rdata);
    end
    ref_a_rdata = 8'hA5;
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_b_read();
    b_req = 1'b1; b_we = 1'b0; b_adr = 3'd0; b_wdata = DW'($urandom);
    tick();
    total++;
    if ({mem_valid, mem_adr} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL b_access: got valid %b adr %h expected 1 0", mem_valid, mem_adr);
    end
    tick();
    total++;
    if ({mem_valid, a_ack, b_ack, b_rdata, a_rdata} !== {3'b001, ref_mem[0], ref_a_rdata}) begin
      bad++; $display("FAIL b_respond: got valid %b ack %b%b rd %h/%h expected 0 01 %h/%h",
                      mem_valid, a_ack, b_ack, a_rdata, b_rdata, ref_a_rdata, ref_mem[0]);
    end
    ref_b_rdata = ref_mem[0]; pref_b = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_adr_stable();
    a_req = 1'b1; a_we = 1'b0; a_adr = 3'd2;
    tick();
    a_adr = 3'd7;
    #1;
    total++;
    if ({mem_valid, mem_adr} !== {1'b1, 3'd2}) begin
      bad++; $display("FAIL adr_stable: got valid %b adr %h expected 1 2", mem_valid, mem_adr);
    end
    tick();
    total++;
    if ({a_ack, a_rdata} !== {1'b1, ref_mem[2]}) begin
      bad++; $display("FAIL adr_stable_data: got ack %b rd %h expected 1 %h", a_ack, a_rdata, ref_mem[2]);
    end
    ref_a_rdata = ref_mem[2]; pref_b = 1'b1;
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old_v, new_v;
    logic [33:0]   outs;
    old_v = ref_mem[3]; new_v = old_v ^ 8'h5A;
    a_req = 1'b1; a_we = 1'b1; a_adr = 3'd3; a_wdata = new_v;
    tick();
    total++;
    if ({mem_valid, mem_we, mem_adr} !== {1'b1, 1'b1, 3'd3}) begin
      bad++; $display("FAIL mid_access: got %b/%b/%h expected 1/1/3", mem_valid, mem_we, mem_adr);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {a_ack, b_ack, a_rdata, b_rdata, mem_valid, mem_we, mem_adr, mem_wdata};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL mid_async_clear: got %h expected 0", outs);
    end
    tick(); tick();
    total++;
    if ({a_ack, b_ack, mem_valid} !== 3'b000) begin
      bad++; $display("FAIL mid_no_ack: got ack %b%b valid %b expected 00 0", a_ack, b_ack, mem_valid);
    end
    a_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ref_a_rdata = '0; ref_b_rdata = '0; pref_b = 1'b0;
    tick();
    a_req = 1'b1; a_we = 1'b0; a_adr = 3'd3;
    tick(); tick();
    total++;
    if (!(a_ack === 1'b1 && (a_rdata === old_v || a_rdata === new_v))) begin
      bad++; $display("FAIL mid_readback: got ack %b rd %h expected 1 %h or %h", a_ack, a_rdata, old_v, new_v);
    end
    ref_mem[3]  = (a_rdata === new_v) ? new_v : old_v;
    ref_a_rdata = ref_mem[3]; pref_b = 1'b1;
    a_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int unsigned   mode;
      logic          wb, e_we;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_wd;
      mode  = $urandom_range(0, 2);
      a_req = (mode != 1); a_we = 1'($urandom); a_adr = AW'($urandom); a_wdata = DW'($urandom);
      b_req = (mode != 0); b_we = 1'($urandom); b_adr = AW'($urandom); b_wdata = DW'($urandom);
      while (a_req || b_req) begin
        wb    = pick_b(a_req, b_req);
        e_adr = wb ? b_adr : a_adr;
        e_we  = wb ? b_we : a_we;
        e_wd  = wb ? b_wdata : a_wdata;
        tick();
        total++;
        if ({mem_valid, mem_we, mem_adr, mem_wdata} !== {1'b1, e_we, e_adr, e_wd}) begin
          bad++; $display("FAIL rand_access_%0d: got %b/%b/%h/%h expected 1/%b/%h/%h", it,
                          mem_valid, mem_we, mem_adr, mem_wdata, e_we, e_adr, e_wd);
        end
        if (e_we)    ref_mem[e_adr] = e_wd;
        else if (wb) ref_b_rdata = ref_mem[e_adr];
        else         ref_a_rdata = ref_mem[e_adr];
        tick();
        total++;
        if ({mem_valid, a_ack, b_ack, a_rdata, b_rdata} !== {1'b0, !wb, wb, ref_a_rdata, ref_b_rdata}) begin
          bad++; $display("FAIL rand_respond_%0d: got valid %b ack %b%b rd %h/%h expected 0 %b%b %h/%h", it,
                          mem_valid, a_ack, b_ack, a_rdata, b_rdata, !wb, wb, ref_a_rdata, ref_b_rdata);
        end
        pref_b = !wb;
        if (wb) b_req = 1'b0;
        else    a_req = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stub_load = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_adr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_adr = '0; b_wdata = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = DW'($urandom);
    ref_a_rdata = '0; ref_b_rdata = '0; pref_b = 1'b0;
    tick(); tick();
    stub_load = 1'b0;
    test_reset();
    test_contention();
    test_write_read();
    test_b_read();
    test_adr_stable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
